// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch sequencer.
package fetch_pkg;
  localparam int BYTE_W  = 8;
  localparam int WORD_W  = 16;
  localparam int LEN_W   = 2;
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH_OP,
    S_FETCH_LO,
    S_FETCH_HI,
    S_HOLD,
    S_ERROR
  } state_t;

  // Opcode bits [7:6]: 00 -> no operand, 01 -> one byte, 1x -> two bytes.
  function automatic logic [LEN_W-1:0] op_len_decode(input logic [BYTE_W-1:0] op);
    logic [1:0] f;
    f = op[LEN_MSB:LEN_LSB];
    return f[1] ? 2'd2 : {1'b0, f[0]};
  endfunction
endpackage

// File: rtl/fetch_wait_timer.sv
// Saturating count of consecutive not-ready memory cycles; flags when the limit is reached.
module fetch_wait_timer #(
  parameter int MAX = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic timeout
);
  localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (inc && cnt != CW'(MAX))
      cnt <= cnt + 1'b1;
  end

  assign timeout = (cnt == CW'(MAX));
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control FSM: steps addrreg through opcode and operand bytes and hands the
// assembled instruction to the decoder with a valid/accept handshake.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 7
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic              JUMP,
  output logic              PC_LOAD_bar,
  output logic              PC_INC,
  output logic              PC_ASSERT_bar,
  output logic              MEM_RD,
  input  logic              MEM_READY,
  input  logic [BYTE_W-1:0] MEM_DATA,
  output logic              INSTR_VALID,
  input  logic              INSTR_ACCEPT,
  output logic [BYTE_W-1:0] OPCODE,
  output logic [WORD_W-1:0] OPERAND,
  output logic [LEN_W-1:0]  OP_LEN,
  output logic              BUSY,
  output logic              ERR
);
  state_t state, state_nxt;
  logic   fetching, timeout, wait_clr;

  assign fetching = (state == S_FETCH_OP) || (state == S_FETCH_LO) || (state == S_FETCH_HI);
  assign wait_clr = (state_nxt != state) || !fetching;

  fetch_wait_timer #(.MAX(MEM_WAIT_MAX)) u_wait (
    .clk     (CLK),
    .rst     (RST),
    .clr     (wait_clr),
    .inc     (fetching && !MEM_READY),
    .timeout (timeout)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      OPCODE  <= '0;
      OPERAND <= '0;
      OP_LEN  <= '0;
    end else begin
      state <= state_nxt;
      if (MEM_READY) begin
        case (state)
          S_FETCH_OP: begin
            OPCODE  <= MEM_DATA;
            OPERAND <= '0;
            OP_LEN  <= op_len_decode(MEM_DATA);
          end
          S_FETCH_LO: OPERAND[BYTE_W-1:0]      <= MEM_DATA;
          S_FETCH_HI: OPERAND[WORD_W-1:BYTE_W] <= MEM_DATA;
          default: ;
        endcase
      end
    end
  end

  // Address-register controls are forced inactive while RST is high so a reset
  // landing mid-fetch never bumps or reloads addrreg.
  always_comb begin
    state_nxt     = state;
    PC_LOAD_bar   = 1'b1;
    PC_INC        = 1'b0;
    PC_ASSERT_bar = 1'b1;
    MEM_RD        = 1'b0;
    INSTR_VALID   = (state == S_HOLD);
    BUSY          = (state != S_IDLE);
    ERR           = (state == S_ERROR);
    if (fetching && !RST) begin
      PC_ASSERT_bar = 1'b0;
      MEM_RD        = 1'b1;
      PC_INC        = MEM_READY;
    end
    if (state == S_LOAD && !RST)
      PC_LOAD_bar = 1'b0;
    case (state)
      S_IDLE:
        if (JUMP)       state_nxt = S_LOAD;
        else if (START) state_nxt = S_FETCH_OP;
      S_LOAD:
        state_nxt = S_IDLE;
      S_FETCH_OP:
        if (MEM_READY)    state_nxt = (op_len_decode(MEM_DATA) != 2'd0) ? S_FETCH_LO : S_HOLD;
        else if (timeout) state_nxt = S_ERROR;
      S_FETCH_LO:
        if (MEM_READY)    state_nxt = (OP_LEN == 2'd2) ? S_FETCH_HI : S_HOLD;
        else if (timeout) state_nxt = S_ERROR;
      S_FETCH_HI:
        if (MEM_READY)    state_nxt = S_HOLD;
        else if (timeout) state_nxt = S_ERROR;
      S_HOLD:
        if (INSTR_ACCEPT) state_nxt = START ? S_FETCH_OP : S_IDLE;
      S_ERROR:
        state_nxt = S_ERROR;
      default:
        state_nxt = S_IDLE;
    endcase
  end
endmodule
